// File: rtl/cpu_if_pkg.sv
// Shared definitions for the CPU command-queue register interface:
// opcode values, status bit positions, dispatcher states and the opcode trigger table.
package cpu_if_pkg;

  localparam logic [7:0] OP_TEXT_WRITE      = 8'h00;
  localparam logic [7:0] OP_TEXT_POSITION   = 8'h01;
  localparam logic [7:0] OP_TEXT_CLEAR      = 8'h02;
  localparam logic [7:0] OP_GET_TEXT_AT     = 8'h03;
  localparam logic [7:0] OP_WRITE_PIXEL     = 8'h04;
  localparam logic [7:0] OP_PIXEL_POS       = 8'h05;
  localparam logic [7:0] OP_WRITE_PIXEL_POS = 8'h06;
  localparam logic [7:0] OP_CLEAR_SCREEN    = 8'h07;
  localparam logic [7:0] OP_GET_PIXEL_AT    = 8'h08;

  localparam int ST_BUSY  = 0;
  localparam int ST_ERR   = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_READY = 7;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_DONE} disp_state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] addr;
  } trig_t;

  // Register address whose write launches the opcode; the last argument it needs.
  function automatic trig_t trigger_addr(input logic [7:0] op);
    trig_t t;
    t.vld  = 1'b1;
    t.addr = 8'd0;
    case (op)
      OP_TEXT_WRITE, OP_TEXT_POSITION, OP_GET_TEXT_AT: t.addr = 8'd3;
      OP_TEXT_CLEAR, OP_WRITE_PIXEL, OP_CLEAR_SCREEN:  t.addr = 8'd2;
      OP_PIXEL_POS, OP_GET_PIXEL_AT:                   t.addr = 8'd5;
      OP_WRITE_PIXEL_POS:                              t.addr = 8'd6;
      default:                                         t.vld  = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: circular buffer with occupancy count; a push into a full
// queue is accepted only when a pop frees the head in the same cycle.
module cmd_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             phi2,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge phi2) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cpu_cmd_queue_interface.sv
// 65C02-facing register file that queues opcode+argument snapshots and
// dispatches them to the execution engine with a start/busy/finished handshake.
module cpu_cmd_queue_interface import cpu_if_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int NUM_ARGS   = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       phi2,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_oe,
  input  logic                       rw,
  input  logic                       ce0,
  input  logic                       ce1b,
  output logic [DATA_W-1:0]          instruction,
  output logic [NUM_ARGS*DATA_W-1:0] arg_bus,
  output logic                       instruction_start,
  input  logic                       instruction_busy,
  input  logic                       instruction_finished,
  input  logic                       instruction_error,
  input  logic [DATA_W-1:0]          result_0,
  input  logic [DATA_W-1:0]          result_1,
  output logic [DATA_W-1:0]          mode_control,
  output logic [$clog2(FIFO_DEPTH):0] queue_level
);
  localparam int TOP   = 2**ADDR_W - 1;
  localparam int CMD_W = DATA_W * (NUM_ARGS + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  if (2 + NUM_ARGS + 3 > 2**ADDR_W) begin : g_map_check
    $error("argument registers overlap result/status registers");
  end

  logic                            sel, wr, rd;
  int                              a;
  logic                            is_arg;
  logic [ADDR_W-1:0]               arg_idx;
  logic [DATA_W-1:0]               mode_reg, opcode_reg, rdata, status;
  logic [NUM_ARGS-1:0][DATA_W-1:0] args_reg, args_byp;
  trig_t                           trig;
  logic                            push, pop, ovf_set;
  logic                            fifo_full, fifo_empty;
  logic [CMD_W-1:0]                head;
  logic                            err_q, ovf_q, rd_stat, rd_stat_q, stat_clr;
  disp_state_t                     state, state_nxt;

  assign sel     = ce0 & ~ce1b;
  assign wr      = sel & ~rw;
  assign rd      = sel & rw;
  assign a       = int'(addr);
  assign is_arg  = (a >= 2) && (a <= 1 + NUM_ARGS);
  assign arg_idx = addr - ADDR_W'(2);

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg   <= '0;
      opcode_reg <= '0;
      args_reg   <= '0;
    end else if (wr) begin
      if (a == 0)      mode_reg          <= data_in;
      else if (a == 1) opcode_reg        <= data_in;
      else if (is_arg) args_reg[arg_idx] <= data_in;
    end
  end

  assign mode_control = mode_reg;

  // The triggering write is usually the last argument, so it must land in the snapshot.
  always_comb begin
    args_byp = args_reg;
    if (wr && is_arg) args_byp[arg_idx] = data_in;
  end

  assign trig    = trigger_addr(8'(opcode_reg));
  assign push    = wr & trig.vld & (addr == ADDR_W'(trig.addr));
  assign ovf_set = push & fifo_full & ~pop;

  cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .phi2    (phi2),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({opcode_reg, args_byp}),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (queue_level)
  );

  assign pop = (state == S_IDLE) & ~fifo_empty & ~instruction_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (pop) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (instruction_finished)  state_nxt = S_IDLE;
                   else if (instruction_busy) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (instruction_finished || !instruction_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      instruction_start <= 1'b0;
      instruction       <= '0;
      arg_bus           <= '0;
    end else begin
      state             <= state_nxt;
      instruction_start <= pop;
      if (pop) begin
        instruction <= head[CMD_W-1 -: DATA_W];
        arg_bus     <= head[NUM_ARGS*DATA_W-1:0];
      end
    end
  end

  // Sticky flags clear only on the first cycle of a status read burst; a new set wins.
  assign rd_stat  = rd & (a == TOP);
  assign stat_clr = rd_stat & ~rd_stat_q;

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_stat_q <= 1'b0;
    end else begin
      err_q     <= instruction_error | (err_q & ~stat_clr);
      ovf_q     <= ovf_set | (ovf_q & ~stat_clr);
      rd_stat_q <= rd_stat;
    end
  end

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = (state != S_IDLE) | instruction_busy | ~fifo_empty;
    status[ST_ERR]   = err_q;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf_q;
    status[ST_READY] = ~fifo_full;
  end

  always_comb begin
    rdata = '0;
    if (a == 0)            rdata = mode_reg;
    else if (a == 1)       rdata = opcode_reg;
    else if (is_arg)       rdata = args_reg[arg_idx];
    else if (a == TOP - 2) rdata = result_0;
    else if (a == TOP - 1) rdata = result_1;
    else if (a == TOP)     rdata = status;
  end

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      data_out <= rd ? rdata : '0;
      data_oe  <= rd;
    end
  end

endmodule

// File: tb/tb_cpu_cmd_queue_interface.sv
// Randomized bench: register-file model plus a scoreboard of expected dispatches,
// checked by an independent monitor on instruction_start.
module tb_cpu_cmd_queue_interface;
  localparam int NARG  = 11;
  localparam int DEPTH = 4;

  logic              phi2 = 1'b0;
  logic              reset_n;
  logic [3:0]        addr;
  logic [7:0]        data_in, data_out, instruction, result_0, result_1, mode_control;
  logic              data_oe, rw, ce0, ce1b;
  logic [NARG*8-1:0] arg_bus;
  logic              instruction_start, instruction_busy, instruction_finished, instruction_error;
  logic [2:0]        queue_level;
  logic              hold_busy, eng_busy, eng_auto;

  assign instruction_busy = hold_busy | eng_busy;

  always #5 phi2 = ~phi2;

  cpu_cmd_queue_interface dut (
    .phi2(phi2), .reset_n(reset_n), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .rw(rw), .ce0(ce0), .ce1b(ce1b),
    .instruction(instruction), .arg_bus(arg_bus), .instruction_start(instruction_start),
    .instruction_busy(instruction_busy), .instruction_finished(instruction_finished),
    .instruction_error(instruction_error), .result_0(result_0), .result_1(result_1),
    .mode_control(mode_control), .queue_level(queue_level)
  );

  typedef struct {
    logic [7:0]        op;
    logic [NARG*8-1:0] args;
  } cmd_t;

  cmd_t       expq[$];
  logic [7:0] mreg[16];
  int         checks = 0, failures = 0, starts = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Which register write launches each opcode (none -> -1).
  function automatic int trig_of(input logic [7:0] op);
    case (op)
      8'h00, 8'h01, 8'h03: return 3;
      8'h02, 8'h04, 8'h07: return 2;
      8'h05, 8'h08:        return 5;
      8'h06:               return 6;
      default:             return -1;
    endcase
  endfunction

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = 8'h00;
    expq.delete();
  endtask

  task automatic bus_wr(input int a, input logic [7:0] d, input bit room, output bit pushed);
    cmd_t c;
    @(negedge phi2);
    addr = 4'(a); data_in = d; rw = 1'b0; ce0 = 1'b1; ce1b = 1'b0;
    pushed = 1'b0;
    if (a <= 12) mreg[a] = d;
    if (a >= 2 && trig_of(mreg[1]) == a && room) begin
      c.op = mreg[1];
      for (int k = 0; k < NARG; k++) c.args[k*8 +: 8] = mreg[2+k];
      expq.push_back(c);
      pushed = 1'b1;
    end
    @(negedge phi2);
    ce0 = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_rd(input int a, output logic [7:0] v, output logic oe);
    @(negedge phi2);
    addr = 4'(a); rw = 1'b1; ce0 = 1'b1; ce1b = 1'b0;
    @(negedge phi2);
    v = data_out; oe = data_oe;
    ce0 = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int a, input logic [7:0] exp);
    logic [7:0] v;
    logic       oe;
    bus_rd(a, v, oe);
    chk({name, "_oe"}, oe, 1'b1);
    chk(name, v, exp);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((expq.size() != 0 || queue_level != 0 || instruction_busy) && n < 2000) begin
      @(negedge phi2);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d level=%0d required 0", expq.size(), queue_level);
    end
    repeat (4) @(negedge phi2);
  endtask

  // Scoreboard monitor: every dispatch must match the oldest expected command.
  always @(negedge phi2) begin
    if (reset_n && instruction_start) begin
      cmd_t e;
      starts++;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start: instruction=%0h with no command pending", instruction);
      end else begin
        e = expq.pop_front();
        chk("dispatch_opcode", instruction, e.op);
        chk("dispatch_args", arg_bus, e.args);
      end
    end
  end

  // Engine model: either a zero-length command or busy for a few cycles then finished.
  initial begin
    eng_busy = 1'b0;
    instruction_finished = 1'b0;
    forever begin
      @(negedge phi2);
      if (reset_n && instruction_start && eng_auto) begin
        int n = $urandom_range(0, 3);
        if (n != 0) begin
          eng_busy = 1'b1;
          repeat (n) @(negedge phi2);
          eng_busy = 1'b0;
        end
        instruction_finished = 1'b1;
        @(negedge phi2);
        instruction_finished = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         p;
    int         s0, lvl;
    logic       seen;
    logic [7:0] v;
    logic       oe;

    reset_n = 1'b0; addr = '0; data_in = '0; rw = 1'b1; ce0 = 1'b0; ce1b = 1'b1;
    hold_busy = 1'b0; eng_auto = 1'b1; instruction_error = 1'b0;
    result_0 = 8'($urandom); result_1 = 8'($urandom);
    model_reset();
    repeat (3) @(negedge phi2);
    #1;
    chk("rst_level", queue_level, 0);
    chk("rst_start", instruction_start, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_args", arg_bus, 0);
    chk("rst_mode", mode_control, 0);
    chk("rst_dout", {data_oe, data_out}, 0);
    reset_n = 1'b1;
    rd_chk("status_after_reset", 15, 8'h80);
    chk("no_start_after_reset", starts, 0);

    // Basic TEXT_WRITE: last argument is bypassed into the snapshot.
    bus_wr(1, 8'h00, 1'b1, p);
    bus_wr(2, 8'h41, 1'b1, p);
    bus_wr(3, 8'h07, 1'b1, p);
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      if (instruction_start) seen = 1'b1;
      else @(negedge phi2);
    end
    chk("start_latency", seen, 1'b1);
    wait_drain();

    // Chip-select gating and mode register.
    @(negedge phi2);
    addr = 4'd0; data_in = 8'h5A; rw = 1'b0; ce0 = 1'b1; ce1b = 1'b1;
    @(negedge phi2);
    ce0 = 1'b0; rw = 1'b1; ce1b = 1'b0;
    chk("ce1b_blocks_write", mode_control, 8'h00);
    bus_wr(0, 8'h3C, 1'b1, p);
    chk("mode_control", mode_control, 8'h3C);
    @(negedge phi2);
    chk("idle_dout", {data_oe, data_out}, 0);

    // Fill the queue behind a busy engine, overflow once, then drain in order.
    hold_busy = 1'b1;
    lvl = 0;
    bus_wr(1, 8'h04, lvl < DEPTH, p);
    for (int i = 1; i <= 4; i++) begin
      bus_wr(2, 8'(i), lvl < DEPTH, p);
      if (p) lvl++;
    end
    chk("full_level", queue_level, 4);
    rd_chk("status_full", 15, 8'h05);
    bus_wr(2, 8'h05, lvl < DEPTH, p);
    chk("drop_level", queue_level, 4);
    rd_chk("status_ovf_first", 15, 8'h0D);
    rd_chk("status_ovf_second", 15, 8'h05);
    hold_busy = 1'b0;
    wait_drain();
    chk("fifo_order_count", starts, 5);

    // Engine error: sticky until a status read.
    @(negedge phi2);
    instruction_error = 1'b1;
    @(negedge phi2);
    instruction_error = 1'b0;
    rd_chk("status_err_first", 15, 8'h82);
    rd_chk("status_err_second", 15, 8'h80);

    // Opcode without a trigger never queues.
    bus_wr(1, 8'h55, 1'b1, p);
    for (int a = 2; a <= 6; a++) bus_wr(a, 8'($urandom), 1'b1, p);
    repeat (3) @(negedge phi2);
    chk("no_trigger_level", queue_level, 0);
    chk("no_trigger_pending", expq.size(), 0);

    // Randomized register traffic with a randomly timed engine.
    for (int it = 0; it < 120; it++) begin
      int act = $urandom_range(0, 9);
      int a;
      logic [7:0] d = 8'($urandom);
      if (act <= 1) begin
        d = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(9, 255));
        bus_wr(1, d, 1'b1, p);
      end else if (act <= 5) begin
        a = $urandom_range(2, 12);
        if (!(trig_of(mreg[1]) == a && queue_level == 3'(DEPTH))) bus_wr(a, d, 1'b1, p);
      end else if (act <= 7) begin
        a = $urandom_range(0, 14);
        rd_chk("rand_read", a, (a <= 12) ? mreg[a] : (a == 13) ? result_0 : result_1);
      end else if (act == 8) begin
        bus_wr(0, d, 1'b1, p);
        chk("rand_mode", mode_control, d);
      end else begin
        bus_wr($urandom_range(13, 15), d, 1'b1, p);
        rd_chk("ro_result_0", 13, result_0);
      end
    end
    wait_drain();

    // Reset in the middle of a command with three more queued.
    eng_auto = 1'b0;
    lvl = 0;
    bus_wr(1, 8'h04, 1'b1, p);
    bus_wr(2, 8'h10, 1'b1, p);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge phi2);
      if (instruction_start) seen = 1'b1;
    end
    chk("reset_test_dispatch", seen, 1'b1);
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) bus_wr(2, 8'(8'h20 + i), lvl < DEPTH, p);
    chk("pre_reset_level", queue_level, 3);
    @(negedge phi2);
    reset_n = 1'b0;
    #1;
    chk("reset_level", queue_level, 0);
    chk("reset_start", instruction_start, 0);
    chk("reset_instr", instruction, 0);
    model_reset();
    repeat (2) @(negedge phi2);
    reset_n = 1'b1;
    hold_busy = 1'b0;
    s0 = starts;
    repeat (12) @(negedge phi2);
    chk("no_dispatch_after_reset", starts, s0);
    rd_chk("status_after_midreset", 15, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_cmd_queue_interface.md
Name: cpu_cmd_queue_interface

Overview:
- Parametrised successor to the single-slot CPU register interface.
- Presents a memory-mapped register file to the 65C02 bus and decodes a trigger write for each opcode.
- Snapshots opcode and arguments into a command FIFO, so the CPU can queue instructions while the execution engine is busy instead of getting an error.
- Dispatches queued commands to the instruction execution engine with a start/busy/finished handshake.

Parameters:
- DATA_W, 8, bus and register width.
- ADDR_W, 4, register address width; map size is 2**ADDR_W.
- NUM_ARGS, 11, number of argument registers. Elaboration requires 2+NUM_ARGS+3 <= 2**ADDR_W.
- FIFO_DEPTH, 4, command queue entries; power of two, >= 2.

Ports:
- phi2  in  1  CPU clock (1 MHz); all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  register address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- data_oe  out  1  high while data_out is valid read data; the top level drives the tristate.
- rw  in  1  1 = read, 0 = write.
- ce0  in  1  chip enable, active high.
- ce1b  in  1  chip enable, active low.
- instruction  out  DATA_W  dispatched opcode.
- arg_bus  out  NUM_ARGS*DATA_W  dispatched args; arg k is at bits [k*DATA_W +: DATA_W].
- instruction_start  out  1  one-cycle dispatch pulse.
- instruction_busy  in  1  engine executing.
- instruction_finished  in  1  one-cycle completion pulse.
- instruction_error  in  1  engine error.
- result_0  in  DATA_W  result byte 0.
- result_1  in  DATA_W  result byte 1.
- mode_control  out  DATA_W  video mode register.
- queue_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Select: sel = ce0 & ~ce1b. wr = sel & ~rw; rd = sel & rw. All writes are synchronous on posedge phi2; no latches.
- Register map: 0 = mode; 1 = opcode; 2..1+NUM_ARGS = args; TOP-2 = result_0; TOP-1 = result_1; TOP = status, where TOP = 2**ADDR_W-1.
  - Results and status are read-only; writes to them are ignored.
  - Unmapped addresses read 0.
- Reads: data_out and data_oe are registered one cycle after rd. When not reading, data_out = 0 and data_oe = 0.
- Trigger addresses (per opcode):
  - 3 for TEXT_WRITE, TEXT_POSITION, GET_TEXT_AT.
  - 2 for TEXT_CLEAR, WRITE_PIXEL, CLEAR_SCREEN.
  - 5 for PIXEL_POS, GET_PIXEL_AT.
  - 6 for WRITE_PIXEL_POS.
  - Any other opcode has no trigger.
- Push: a write to the trigger address of the current opcode pushes {opcode, args}.
  - The arg being written that cycle is taken from data_in (bypass), not from the stale register.
- Full queue: a push while full and with no pop that cycle is dropped and sets the sticky OVF bit.
  - A simultaneous push and pop while full is accepted; occupancy is unchanged.
- Dispatcher FSM:
  - IDLE: if FIFO non-empty and !instruction_busy, pop the head, register instruction and arg_bus, and pulse instruction_start for one cycle -> WAIT_ACK.
  - WAIT_ACK: on instruction_busy=1 -> WAIT_DONE; on instruction_finished=1 (zero-length command) -> IDLE.
  - WAIT_DONE: on instruction_finished=1 or instruction_busy=0 -> IDLE.
  - Commands are never re-dispatched; the minimum spacing between starts is 2 cycles.
- Status register:
  - bit0 BUSY = (state != IDLE) | instruction_busy | non-empty FIFO.
  - bit1 ERR: set by instruction_error; clear-on-read.
  - bit2 FULL.
  - bit3 OVF: sticky; clear-on-read.
  - bit7 READY = ~FULL.
  - All other bits read 0.
  - Clear-on-read applies only on the first cycle of a status read burst (edge of rd & addr==TOP). A set in the same cycle wins over the clear.
  - ERR is not cleared by instruction_finished.
- Reset values: all registers 0, FIFO empty, FSM IDLE.
  - Outputs: data_out=0, data_oe=0, instruction=0, arg_bus=0, instruction_start=0, mode_control=0, queue_level=0.
  - Reset asserted mid-command flushes the queue and drops any command in flight.
- mode_control updates on the cycle after the write to address 0 and equals register 0.

Decomposition:
- Package cpu_if_pkg holds:
  - opcode localparams;
  - status bit indices;
  - function trigger_addr(opcode) returning the address plus a valid flag.
- One sub-module: cmd_fifo.
  - Parametrised width (DATA_W*(NUM_ARGS+1)) and depth.
  - Synchronous push/pop with full, empty and level outputs.
  - Supports simultaneous push and pop when full.

Test Plan:
- Reset then read addr 15 -> data_out=0x80; queue_level=0; instruction_start never pulses.
- Write opcode 0x00 to addr1, 0x41 to addr2, 0x07 to addr3 with busy=0 -> start pulses within 2 cycles; instruction=0x00; args 0/1 = 0x41/0x07.
- Hold busy=1 and queue 4 WRITE_PIXEL commands (addr2 = 1,2,3,4) -> queue_level=4; status=0x05 (BUSY|FULL, READY=0).
  - Then pulse finished, dropping busy, 4 times -> dispatch order 1,2,3,4.
- With the queue full, a 5th trigger -> dropped; status bit3=1.
  - The first status read returns 0x0D; the second read returns 0x05.
- Write opcode 0x55 then addrs 2..6 -> no push; queue_level stays 0.
- Assert reset_n=0 mid-WAIT_DONE with 3 queued -> immediate queue_level=0 and start=0.
  - After release, no dispatch occurs.
